// File: rtl/fc_tcdm_pkg.sv
// Shared types and constants for the fabric-controller TCDM responder.
package fc_tcdm_pkg;

  typedef struct packed {
    logic valid;
    logic err;
  } tcdm_resp_t;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADACCE5;

  localparam int unsigned MEM_LATENCY_MIN = 1;
  localparam int unsigned MEM_LATENCY_MAX = 3;

endpackage

// File: rtl/fc_tcdm_resp_pipe.sv
// Response tracking shift register: one {valid, err} slot per SRAM latency cycle,
// cleared synchronously by flush_i so no pre-flush response can escape.
module fc_tcdm_resp_pipe
  import fc_tcdm_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic       clk_i,
  input  logic       flush_i,
  input  tcdm_resp_t in_i,
  output tcdm_resp_t out_o
);

  tcdm_resp_t [DEPTH-1:0] stage_q;
  tcdm_resp_t [DEPTH-1:0] stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = in_i;
    for (int i = 1; i < int'(DEPTH); i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (flush_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_o = stage_q[DEPTH-1];

endmodule

// File: rtl/fc_tcdm_responder.sv
// TCDM request/grant slave in front of a fixed-latency single-port SRAM:
// decodes the window, tracks one response per grant in order, latches the first decode error.
module fc_tcdm_responder
  import fc_tcdm_pkg::*;
#(
  parameter logic [31:0] MEM_BASE    = 32'h1C000000,
  parameter int unsigned MEM_SIZE    = 32768,
  parameter int unsigned MEM_LATENCY = 1,
  parameter logic [31:0] ERR_RDATA   = ERR_RDATA_DEFAULT,
  localparam int unsigned AW         = $clog2(MEM_SIZE) - 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_i,
  input  logic [31:0]   add_i,
  input  logic          wen_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    be_i,
  output logic          gnt_o,
  output logic          r_valid_o,
  output logic [31:0]   r_rdata_o,
  output logic          r_opc_o,
  input  logic          stall_i,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  output logic [3:0]    mem_be_o,
  input  logic [31:0]   mem_rdata_i,
  output logic          err_valid_o,
  output logic [31:0]   err_addr_o,
  output logic          err_overflow_o,
  input  logic          err_clr_i
);

  localparam logic [31:0] MEM_SIZE_W = 32'(MEM_SIZE);

  if (MEM_LATENCY < MEM_LATENCY_MIN || MEM_LATENCY > MEM_LATENCY_MAX) begin : g_bad_latency
    $error("fc_tcdm_responder: MEM_LATENCY must be within 1..3");
  end
  if (MEM_SIZE < 4 || (MEM_SIZE & (MEM_SIZE - 1)) != 0) begin : g_bad_size
    $error("fc_tcdm_responder: MEM_SIZE must be a power of two, at least 4");
  end

  logic [31:0] offset;
  logic        in_range;
  logic        handshake;
  logic        err_hs;

  tcdm_resp_t  pipe_in;
  tcdm_resp_t  pipe_out;

  logic        err_valid_q, err_valid_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic        err_overflow_q, err_overflow_d;

  // Subtract-then-compare makes addresses below the base wrap high and fall out of range.
  assign offset    = add_i - MEM_BASE;
  assign in_range  = offset < MEM_SIZE_W;
  assign gnt_o     = req_i & ~stall_i & ~rst_i;
  assign handshake = req_i & gnt_o;
  assign err_hs    = handshake & ~in_range;

  assign mem_req_o   = handshake & in_range;
  assign mem_we_o    = ~wen_i;
  assign mem_addr_o  = offset[AW+1:2];
  assign mem_wdata_o = wdata_i;
  assign mem_be_o    = be_i;

  assign pipe_in.valid = handshake;
  assign pipe_in.err   = err_hs;

  fc_tcdm_resp_pipe #(
    .DEPTH (MEM_LATENCY)
  ) u_resp_pipe (
    .clk_i   (clk_i),
    .flush_i (rst_i),
    .in_i    (pipe_in),
    .out_o   (pipe_out)
  );

  assign r_valid_o = pipe_out.valid;
  assign r_opc_o   = pipe_out.err;
  assign r_rdata_o = !pipe_out.valid ? 32'h0 :
                     pipe_out.err    ? ERR_RDATA : mem_rdata_i;

  // Clear is applied first so an error arriving in the same cycle is still captured.
  always_comb begin
    err_valid_d    = err_valid_q;
    err_addr_d     = err_addr_q;
    err_overflow_d = err_overflow_q;
    if (err_clr_i) begin
      err_valid_d    = 1'b0;
      err_addr_d     = 32'h0;
      err_overflow_d = 1'b0;
    end
    if (err_hs) begin
      if (err_valid_d) begin
        err_overflow_d = 1'b1;
      end else begin
        err_valid_d    = 1'b1;
        err_addr_d     = add_i;
        err_overflow_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_valid_q    <= 1'b0;
      err_addr_q     <= 32'h0;
      err_overflow_q <= 1'b0;
    end else begin
      err_valid_q    <= err_valid_d;
      err_addr_q     <= err_addr_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign err_valid_o    = err_valid_q;
  assign err_addr_o     = err_addr_q;
  assign err_overflow_o = err_overflow_q;

endmodule

// File: tb/tb_fc_tcdm_responder.sv
// Bench for fc_tcdm_responder: identical stimulus into a latency-1 and a latency-3
// instance, each backed by its own SRAM model, responses scored against a shared queue.
module tb_fc_tcdm_responder;

  localparam logic [31:0] BASE = 32'h1C000000;
  localparam logic [31:0] SIZE = 32'd32768;
  localparam logic [31:0] ERRD = 32'hBADACCE5;
  localparam int          AW   = 13;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [31:0] add = 32'h0;
  logic        wen = 1'b1;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  be = 4'h0;
  logic        stall = 1'b0;
  logic        err_clr = 1'b0;

  logic [1:0]    gnt, r_valid, r_opc, mem_req, mem_we, err_valid, err_ovf;
  logic [31:0]   r_rdata   [2];
  logic [31:0]   mem_wdata [2];
  logic [31:0]   mem_rdata [2];
  logic [31:0]   err_addr  [2];
  logic [3:0]    mem_be    [2];
  logic [AW-1:0] mem_addr  [2];

  always #5 clk = ~clk;

  fc_tcdm_responder #(.MEM_LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt[0]), .r_valid_o(r_valid[0]),
    .r_rdata_o(r_rdata[0]), .r_opc_o(r_opc[0]), .stall_i(stall),
    .mem_req_o(mem_req[0]), .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]),
    .mem_wdata_o(mem_wdata[0]), .mem_be_o(mem_be[0]), .mem_rdata_i(mem_rdata[0]),
    .err_valid_o(err_valid[0]), .err_addr_o(err_addr[0]),
    .err_overflow_o(err_ovf[0]), .err_clr_i(err_clr)
  );

  fc_tcdm_responder #(.MEM_LATENCY(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt[1]), .r_valid_o(r_valid[1]),
    .r_rdata_o(r_rdata[1]), .r_opc_o(r_opc[1]), .stall_i(stall),
    .mem_req_o(mem_req[1]), .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]),
    .mem_wdata_o(mem_wdata[1]), .mem_be_o(mem_be[1]), .mem_rdata_i(mem_rdata[1]),
    .err_valid_o(err_valid[1]), .err_addr_o(err_addr[1]),
    .err_overflow_o(err_ovf[1]), .err_clr_i(err_clr)
  );

  // SRAM models: read-before-write, data emerges after the instance's latency
  logic [31:0] sram  [2][8192];
  logic [31:0] rpipe [2][3];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int s = 2; s > 0; s--) rpipe[d][s] <= rpipe[d][s-1];
      if (mem_req[d]) begin
        rpipe[d][0] <= sram[d][mem_addr[d]];
        if (mem_we[d]) begin
          for (int b = 0; b < 4; b++) begin
            if (mem_be[d][b]) sram[d][mem_addr[d]][8*b +: 8] <= mem_wdata[d][8*b +: 8];
          end
        end
      end
    end
  end

  assign mem_rdata[0] = rpipe[0][0];
  assign mem_rdata[1] = rpipe[1][2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: one entry per handshake, consumed independently by each instance
  typedef struct {
    int          cyc;
    logic        err;
    logic        known;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb [$];
  int          rd [2] = '{0, 0};
  logic [31:0] ref_mem [int unsigned];

  exp_t        e;
  logic [31:0] off, nv;
  int unsigned idx;
  int          lat;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      lat = (d == 0) ? 1 : 3;
      if (r_valid[d]) begin
        if (rd[d] >= sb.size()) begin
          chk($sformatf("unexpected_resp_L%0d", lat), 32'(r_valid[d]), 32'h0);
        end else begin
          e = sb[rd[d]];
          rd[d]++;
          chk($sformatf("resp_latency_L%0d", lat), 32'(cyc), 32'(e.cyc + lat));
          chk($sformatf("resp_opc_L%0d", lat), 32'(r_opc[d]), 32'(e.err));
          if (e.known) chk($sformatf("resp_rdata_L%0d", lat), r_rdata[d], e.rdata);
          $display("resp L%0d cyc=%0d opc=%0b rdata=%h", lat, cyc, r_opc[d], r_rdata[d]);
        end
      end else begin
        chk($sformatf("idle_rdata_L%0d", lat), r_rdata[d], 32'h0);
        chk($sformatf("idle_opc_L%0d", lat), 32'(r_opc[d]), 32'h0);
        if (rd[d] < sb.size() && sb[rd[d]].cyc + lat <= cyc) begin
          chk($sformatf("resp_missing_L%0d", lat), 32'(r_valid[d]), 32'h1);
          rd[d]++;
        end
      end
    end
    if (req && !stall && !rst) begin
      off     = add - BASE;
      idx     = off >> 2;
      e.cyc   = cyc;
      e.err   = !(off < SIZE);
      e.known = e.err || ref_mem.exists(idx);
      e.rdata = e.err ? ERRD : (ref_mem.exists(idx) ? ref_mem[idx] : 32'h0);
      if (!e.err && !wen) begin
        if (ref_mem.exists(idx) || be == 4'hF) begin
          nv = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
          for (int b = 0; b < 4; b++) if (be[b]) nv[8*b +: 8] = wdata[8*b +: 8];
          ref_mem[idx] = nv;
        end
      end
      sb.push_back(e);
      $display("txn cyc=%0d %s add=%h wdata=%h be=%h err=%0b", cyc, wen ? "RD" : "WR",
               add, wdata, be, e.err);
    end
    if (rst) begin
      rd[0] = sb.size();
      rd[1] = sb.size();
    end
  end

  task automatic drive(input logic r, input logic [31:0] a, input logic w,
                       input logic [31:0] wd, input logic [3:0] b, input logic s);
    req = r; add = a; wen = w; wdata = wd; be = b; stall = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_err(input string name, input logic v, input logic [31:0] a, input logic o);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_valid_%0d", name, d), 32'(err_valid[d]), 32'(v));
      chk($sformatf("%s_addr_%0d", name, d), err_addr[d], a);
      chk($sformatf("%s_ovf_%0d", name, d), 32'(err_ovf[d]), 32'(o));
    end
  endtask

  typedef struct {
    logic          req;
    logic [31:0]   add;
    logic          wen;
    logic [31:0]   wdata;
    logic [3:0]    be;
    logic          stall;
    logic          exp_gnt;
    logic          exp_mreq;
    logic [AW-1:0] exp_maddr;
  } vec_t;

  vec_t vt [12];

  initial begin
    vt[0]  = '{1'b1, 32'h1C000010, 1'b0, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 1'b1, 13'd4};
    vt[1]  = '{1'b1, 32'h1C000010, 1'b1, 32'h00000000, 4'hF, 1'b0, 1'b1, 1'b1, 13'd4};
    vt[2]  = '{1'b1, 32'h1C007FFC, 1'b0, 32'h12345678, 4'hF, 1'b0, 1'b1, 1'b1, 13'd8191};
    vt[3]  = '{1'b1, 32'h1C007FFC, 1'b1, 32'h00000000, 4'hF, 1'b0, 1'b1, 1'b1, 13'd8191};
    vt[4]  = '{1'b1, 32'h1C000013, 1'b1, 32'h00000000, 4'hF, 1'b0, 1'b1, 1'b1, 13'd4};
    vt[5]  = '{1'b1, 32'h1C008000, 1'b1, 32'h00000000, 4'hF, 1'b0, 1'b1, 1'b0, 13'd0};
    vt[6]  = '{1'b1, 32'h1BFFFFFC, 1'b0, 32'h00000055, 4'hF, 1'b0, 1'b1, 1'b0, 13'd0};
    vt[7]  = '{1'b1, 32'h1C000020, 1'b0, 32'hCAFEF00D, 4'hF, 1'b0, 1'b1, 1'b1, 13'd8};
    vt[8]  = '{1'b1, 32'h1C000020, 1'b0, 32'h0000AB00, 4'h2, 1'b0, 1'b1, 1'b1, 13'd8};
    vt[9]  = '{1'b0, 32'h1C000020, 1'b1, 32'h00000000, 4'hF, 1'b0, 1'b0, 1'b0, 13'd0};
    vt[10] = '{1'b1, 32'h1C000020, 1'b1, 32'h00000000, 4'hF, 1'b1, 1'b0, 1'b0, 13'd0};
    vt[11] = '{1'b1, 32'h1C000020, 1'b1, 32'h00000000, 4'hF, 1'b0, 1'b1, 1'b1, 13'd8};

    // Reset state
    drive(1'b1, BASE, 1'b1, 32'h0, 4'hF, 1'b0);
    repeat (3) tick();
    @(negedge clk);
    chk("rst_blocks_gnt", 32'(gnt), 32'h0);
    chk("rst_blocks_mem_req", 32'(mem_req), 32'h0);
    drive(1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 1'b0);
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("reset_r_valid", 32'(r_valid), 32'h0);
    chk_err("reset_err", 1'b0, 32'h0, 1'b0);

    // Table-driven single-cycle vectors
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].req, vt[i].add, vt[i].wen, vt[i].wdata, vt[i].be, vt[i].stall);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("vec%0d_gnt_%0d", i, d), 32'(gnt[d]), 32'(vt[i].exp_gnt));
        chk($sformatf("vec%0d_mem_req_%0d", i, d), 32'(mem_req[d]), 32'(vt[i].exp_mreq));
        if (vt[i].exp_mreq) begin
          chk($sformatf("vec%0d_mem_addr_%0d", i, d), 32'(mem_addr[d]), 32'(vt[i].exp_maddr));
          chk($sformatf("vec%0d_mem_we_%0d", i, d), 32'(mem_we[d]), 32'(!vt[i].wen));
          chk($sformatf("vec%0d_mem_wdata_%0d", i, d), mem_wdata[d], vt[i].wdata);
          chk($sformatf("vec%0d_mem_be_%0d", i, d), 32'(mem_be[d]), 32'(vt[i].be));
        end
      end
      tick();
    end
    drive(1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 1'b0);
    repeat (4) tick();

    // Decode error capture, overflow and clear
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    chk_err("pre_clear", 1'b0, 32'h0, 1'b0);
    drive(1'b1, 32'h1C008000, 1'b1, 32'h0, 4'hF, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    chk_err("first_err", 1'b1, 32'h1C008000, 1'b0);
    drive(1'b1, 32'h20000000, 1'b0, 32'h1, 4'hF, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    chk_err("second_err", 1'b1, 32'h1C008000, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    chk_err("cleared", 1'b0, 32'h0, 1'b0);

    // Stall for 4 cycles, grant on the first unstalled cycle
    drive(1'b1, 32'h1C000010, 1'b1, 32'h0, 4'hF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_gnt", i), 32'(gnt), 32'h0);
      chk($sformatf("stall%0d_mem_req", i), 32'(mem_req), 32'h0);
      tick();
    end
    stall = 1'b0;
    @(negedge clk);
    chk("unstall_gnt", 32'(gnt), 32'h3);
    chk("unstall_mem_req", 32'(mem_req), 32'h3);
    tick();

    // Streaming: 8 back-to-back writes then 8 back-to-back reads
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h1C000100 + 32'(4 * i), 1'b0, 32'h11111111 * 32'(i + 1), 4'hF, 1'b0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h1C000100 + 32'(4 * i), 1'b1, 32'h0, 4'hF, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 1'b0);
    repeat (5) tick();

    // Reset one cycle after two handshakes; request held through reset
    drive(1'b1, 32'h1C000104, 1'b1, 32'h0, 4'hF, 1'b0);
    repeat (2) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_gnt", 32'(gnt), 32'h0);
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_r_valid", i), 32'(r_valid), 32'h0);
      tick();
    end

    // Clear and new error at 0x0 in the same cycle
    drive(1'b1, 32'h1C008000, 1'b1, 32'h0, 4'hF, 1'b0);
    tick();
    drive(1'b1, 32'h00000000, 1'b1, 32'h0, 4'hF, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    chk_err("set_after_clear", 1'b1, 32'h0, 1'b0);

    repeat (6) tick();
    @(negedge clk);
    chk("drained_L1", 32'(rd[0]), 32'(sb.size()));
    chk("drained_L3", 32'(rd[1]), 32'(sb.size()));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
